// File: rtl/image_stream_loader.sv
// Streams a raster-ordered frame of signed pixels into a register-array image buffer.
// Holds the completed frame for the accelerator until the consumer acknowledges it.
module image_stream_loader #(
    parameter int bitwidth = 32,
    parameter int img_dim  = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [bitwidth-1:0] s_data,
    input  logic                       s_last,
    output logic signed [bitwidth-1:0] image [img_dim-1:0][img_dim-1:0],
    output logic                       img_valid,
    input  logic                       img_ack,
    output logic [9:0]                 pix_cnt,
    output logic                       frame_err
);

    localparam int unsigned DIM      = img_dim;
    localparam int unsigned NPIX     = DIM * DIM;
    localparam int unsigned RW       = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [RW-1:0] COL_MAX  = RW'(DIM - 1);
    localparam logic [9:0]    LAST_CNT = 10'(NPIX - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                      r_state;
    logic [RW-1:0]               r_row;
    logic [RW-1:0]               r_col;
    logic [9:0]                  r_pix_cnt;
    logic                        r_ready;
    logic                        r_valid;
    logic                        r_err;
    logic signed [bitwidth-1:0]  r_image [img_dim-1:0][img_dim-1:0];

    logic w_accept;
    logic w_frame_end;

    // r_ready is held low through reset and only rises on the first edge after release.
    assign w_accept    = s_valid && r_ready;
    assign w_frame_end = (r_pix_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FILL;
            r_row     <= '0;
            r_col     <= '0;
            r_pix_cnt <= '0;
            r_ready   <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            for (int unsigned i = 0; i < DIM; i++) begin
                for (int unsigned j = 0; j < DIM; j++) begin
                    r_image[i][j] <= '0;
                end
            end
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                FILL: begin
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    if (w_accept) begin
                        r_image[r_row][r_col] <= s_data;
                        if (w_frame_end) begin
                            r_state   <= HOLD;
                            r_ready   <= 1'b0;
                            r_valid   <= 1'b1;
                            r_pix_cnt <= r_pix_cnt + 10'd1;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_err     <= ~s_last;
                        end else if (s_last) begin
                            // Early end of frame: pixel is kept, frame position restarts.
                            r_pix_cnt <= '0;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_err     <= 1'b1;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 10'd1;
                            if (r_col == COL_MAX) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (img_ack) begin
                        r_state   <= FILL;
                        r_ready   <= 1'b1;
                        r_valid   <= 1'b0;
                        r_pix_cnt <= '0;
                        r_row     <= '0;
                        r_col     <= '0;
                    end
                end
            endcase
        end
    end

    assign s_ready   = r_ready;
    assign img_valid = r_valid;
    assign pix_cnt   = r_pix_cnt;
    assign frame_err = r_err;
    assign image     = r_image;

endmodule

// File: doc/image_stream_loader.md
IMAGE_STREAM_LOADER -- requirements
Module: image_stream_loader

Interface
REQ-001 Parameter bitwidth, default 32, pixel word width in bits (signed).
REQ-002 Parameter img_dim, default 28, image side length; the frame holds img_dim*img_dim pixels.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  upstream pixel valid.
REQ-006 s_ready  output  1  loader can accept a pixel this cycle.
REQ-007 s_data  input  bitwidth  signed pixel value.
REQ-008 s_last  input  1  marks the final pixel of a frame; sampled only on a handshake.
REQ-009 image  output  signed [bitwidth-1:0] array [img_dim-1:0][img_dim-1:0]  frame buffer, indexed [row][col], driven to the accelerator image port.
REQ-010 img_valid  output  1  image holds a complete frame.
REQ-011 img_ack  input  1  consumer has finished with the frame.
REQ-012 pix_cnt  output  10  pixels accepted in the current frame.
REQ-013 frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-014 Handshake: a pixel is accepted when s_valid and s_ready are both high at a rising clk edge; there is no other way to accept a pixel.
REQ-015 State machine: two states, FILL and HOLD; s_ready = (state==FILL), img_valid = (state==HOLD); both are registered.
REQ-016 FILL: an accepted pixel is written to image[row][col]; col then increments, and on col==img_dim-1 it wraps to 0 and row increments; pix_cnt increments by 1.
REQ-017 Raster order: row-major, with the first pixel at image[0][0] and pixel 784 at image[27][27].
REQ-018 Normal completion: acceptance of pixel number img_dim*img_dim with s_last=1 moves the block to HOLD on that edge; img_valid goes high and s_ready goes low in the next cycle, so completion latency is 1 cycle.
REQ-019 Early s_last: s_last=1 on a pixel before pixel img_dim*img_dim discards the frame:
  - the pixel is still written to the buffer;
  - row, col and pix_cnt clear to 0;
  - state remains FILL;
  - frame_err pulses for 1 cycle.
REQ-020 Missing s_last: pixel img_dim*img_dim accepted with s_last=0 still completes the frame (REQ-018) and frame_err pulses for 1 cycle.
REQ-021 HOLD: the image contents are frozen, s_ready=0, and s_valid, s_data and s_last are ignored.
REQ-022 img_ack in HOLD returns the block to FILL on that edge:
  - row, col and pix_cnt clear;
  - image contents are retained until overwritten.
REQ-023 img_ack in FILL is ignored.
REQ-024 pix_cnt reads img_dim*img_dim throughout HOLD.
REQ-025 The image output is a direct register output, with no combinational path from s_data.
REQ-026 There is no back-to-back bypass: the first pixel of the next frame is accepted no earlier than the cycle after img_ack.

Reset
REQ-027 rst=1 asynchronously forces the following, regardless of clk:
  - state=FILL, row=col=0, pix_cnt=0;
  - frame_err=0, img_valid=0;
  - every image element to 0.
REQ-028 s_ready is 0 while rst is high and 1 from the first rising edge after rst deasserts.
REQ-029 Reset asserted mid-frame or in HOLD discards the partial or complete frame; no frame_err pulse is generated.

Verification
REQ-030 Stream pixels 0..783 with s_valid held high and s_last on pixel 783:
  - img_valid rises exactly 1 cycle after the last handshake;
  - image[r][c] == 28*r+c for every element;
  - frame_err never pulses;
  - pix_cnt==784.
REQ-031 Same stream with s_valid randomly deasserted 50% of cycles -> identical image contents, and pix_cnt advances only on handshakes.
REQ-032 s_last asserted on pixel 99:
  - frame_err pulses 1 cycle;
  - pix_cnt returns to 0 and img_valid stays 0;
  - a following full 784-pixel frame completes correctly.
REQ-033 In HOLD, drive s_valid=1 with s_data=-1 for 20 cycles -> image unchanged and s_ready=0; then img_ack=1 for 1 cycle -> s_ready=1 and img_valid=0 next cycle.
REQ-034 Assert rst asynchronously (between edges) after 400 pixels:
  - all outputs and the image clear immediately;
  - after release, a full frame loads from image[0][0].
REQ-035 784 pixels with no s_last -> HOLD is entered and frame_err pulses exactly once, on the completing cycle.
